// File: rtl/mac_acc_drain.sv
// mac_acc_drain: captures a 22-bit accumulator word and drains it as bytes, LSB first.
// Define MAC_DRAIN_SAT_EN to clamp each word to signed 16 bits and emit 2 bytes instead of 3.
module mac_acc_drain (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] acc_in,
    input  logic        acc_vld,
    output logic        acc_rdy,
    output logic [7:0]  dout,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic        dout_last,
    output logic        ovr,
    output logic        sat_flag
);
    typedef enum logic {IDLE, SEND} state_t;
`ifdef MAC_DRAIN_SAT_EN
    localparam logic [1:0] LAST_IDX = 2'd1;
    logic over, under;
    assign over  = $signed(acc_in) > 22'sd32767;
    assign under = $signed(acc_in) < -22'sd32768;
    logic [21:0] cap;
    logic        cap_sat;
    assign cap     = over ? 22'h007FFF : under ? 22'h3F8000 : acc_in;
    assign cap_sat = over | under;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
    logic [21:0] cap;
    logic        cap_sat;
    assign cap     = acc_in;
    assign cap_sat = 1'b0;
`endif
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [21:0] held_q, held_d;
    logic        ovr_q, ovr_d;
    logic        sat_q, sat_d;
    logic [7:0]  dout_q, dout_d;
    logic        last_q, last_d;
    function automatic logic [7:0] pick(input logic [21:0] h, input logic [1:0] i);
        return i == 2'd0 ? h[7:0] : i == 2'd1 ? h[15:8] : {h[21], h[21], h[21:16]};
    endfunction
    // Output byte and last flag are registered from the next-state view so they align with dout_vld.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        held_d  = held_q;
        ovr_d   = ovr_q;
        sat_d   = sat_q;
        if (state_q == IDLE) begin
            if (acc_vld) begin
                state_d = SEND;
                idx_d   = 2'd0;
                held_d  = cap;
                sat_d   = cap_sat;
            end
        end else begin
            if (acc_vld)
                ovr_d = 1'b1;
            if (dout_rdy) begin
                if (idx_q == LAST_IDX)
                    state_d = IDLE;
                else
                    idx_d = idx_q + 2'd1;
            end
        end
        dout_d = state_d == SEND ? pick(held_d, idx_d) : 8'h00;
        last_d = state_d == SEND && idx_d == LAST_IDX;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            held_q  <= 22'd0;
            ovr_q   <= 1'b0;
            sat_q   <= 1'b0;
            dout_q  <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            held_q  <= held_d;
            ovr_q   <= ovr_d;
            sat_q   <= sat_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
        end
    end
    assign acc_rdy   = state_q == IDLE;
    assign dout_vld  = state_q == SEND;
    assign dout      = dout_q;
    assign dout_last = last_q;
    assign ovr       = ovr_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_mac_acc_drain.sv
// tb_mac_acc_drain: directed and randomized checks of mac_acc_drain against a byte-level model.
module tb_mac_acc_drain;
    logic        clk = 1'b0;
    logic        reset, acc_vld, dout_rdy;
    logic        acc_rdy, dout_vld, dout_last, ovr, sat_flag;
    logic [21:0] acc_in;
    logic [7:0]  dout;
    int          compared = 0;
    int          mismatched = 0;
    logic        ovr_exp = 1'b0;
`ifdef MAC_DRAIN_SAT_EN
    localparam int NB = 2;
`else
    localparam int NB = 3;
`endif
    always #5 clk = ~clk;
    mac_acc_drain dut (
        .clk(clk), .reset(reset), .acc_in(acc_in), .acc_vld(acc_vld), .acc_rdy(acc_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_last(dout_last),
        .ovr(ovr), .sat_flag(sat_flag)
    );
    function automatic int model_val(input logic [21:0] w);
        int v;
        v = $signed(w);
`ifdef MAC_DRAIN_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v;
    endfunction
    function automatic logic [31:0] model_byte(input logic [21:0] w, input int k);
        return (model_val(w) >>> (8 * k)) & 255;
    endfunction
    function automatic logic [31:0] model_sat(input logic [21:0] w);
        int v;
        v = $signed(w);
`ifdef MAC_DRAIN_SAT_EN
        return (v > 32767 || v < -32768) ? 1 : 0;
`else
        return (v == v + 1) ? 1 : 0;
`endif
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic run_word(input logic [21:0] w, input int stall_k, input int stall_n, input bit ovr_pulse);
        @(negedge clk);
        chk("acc_rdy_idle", acc_rdy, 1);
        acc_in  = w;
        acc_vld = 1'b1;
        @(negedge clk);
        acc_vld = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k == stall_k) begin
                dout_rdy = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk("stall_vld", dout_vld, 1);
                    chk("stall_dout", dout, model_byte(w, k));
                    chk("stall_last", dout_last, k == NB - 1);
                    @(negedge clk);
                end
                dout_rdy = 1'b1;
            end
            chk("dout_vld", dout_vld, 1);
            chk("dout", dout, model_byte(w, k));
            chk("dout_last", dout_last, k == NB - 1);
            chk("acc_rdy_busy", acc_rdy, 0);
            chk("sat_flag", sat_flag, model_sat(w));
            if (ovr_pulse && k == 0) begin
                acc_vld = 1'b1;
                acc_in  = 22'h000001;
                ovr_exp = 1'b1;
            end
            @(negedge clk);
            acc_vld = 1'b0;
        end
        chk("end_vld", dout_vld, 0);
        chk("end_acc_rdy", acc_rdy, 1);
        chk("end_dout", dout, 0);
        chk("end_last", dout_last, 0);
        chk("ovr", ovr, ovr_exp);
    endtask
    initial begin
        reset    = 1'b1;
        acc_vld  = 1'b0;
        dout_rdy = 1'b1;
        acc_in   = 22'd0;
        #1;
        chk("rst_acc_rdy", acc_rdy, 1);
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_sat", sat_flag, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_word(22'h012345, -1, 0, 1'b0);
        run_word(22'h3FFFFF, -1, 0, 1'b0);
        run_word(22'h200000, -1, 0, 1'b0);
        run_word(22'h000123, -1, 0, 1'b0);
        run_word(22'h012345, 1, 3, 1'b0);
        run_word(22'h012345, -1, 0, 1'b1);
        for (int i = 0; i < 24; i++)
            run_word(22'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                     bit'($urandom_range(0, 1)));
        @(negedge clk);
        acc_in  = 22'h012345;
        acc_vld = 1'b1;
        @(negedge clk);
        acc_vld = 1'b0;
        chk("pre_rst_byte0", dout, model_byte(22'h012345, 0));
        @(negedge clk);
        chk("pre_rst_byte1", dout, model_byte(22'h012345, 1));
        reset = 1'b1;
        #1;
        ovr_exp = 1'b0;
        chk("mid_rst_vld", dout_vld, 0);
        chk("mid_rst_acc_rdy", acc_rdy, 1);
        chk("mid_rst_ovr", ovr, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_last", dout_last, 0);
        chk("mid_rst_sat", sat_flag, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_vld", dout_vld, 0);
            chk("post_rst_acc_rdy", acc_rdy, 1);
        end
        run_word(22'h3ABCDE, -1, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
